// File: rtl/prefix_sched_pkg.sv
// Shared types and constants for the prefix-pipe scheduler: datapath latency,
// requester tag width and the valid/tag slot carried beside the datapath.
package prefix_sched_pkg;

    localparam int PIPE_LATENCY = 5;
    localparam int MAX_REQ      = 16;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_W = tag_w(MAX_REQ);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic vld;
        tag_t tag;
    } slot_t;

endpackage

// File: rtl/sched_res_fifo.sv
// Per-requester result FIFO: registered storage, no same-cycle bypass,
// pointers wrap modulo DEPTH so any depth >= 1 works.
module sched_res_fifo
    import prefix_sched_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              not_empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = tag_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign do_pop    = pop & not_empty;
    assign do_push   = push & (~full | do_pop);
    assign head      = mem[rd_ptr];

    // NOTE: storage has no reset; count and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefix_pipe_scheduler.sv
// Shares one pipelined kgp datapath between N_REQ requesters: round-robin issue,
// credit-gated so each requester's result FIFO can never overflow. N_REQ <= MAX_REQ.
module prefix_pipe_scheduler
    import prefix_sched_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 128,
    parameter int LATENCY   = PIPE_LATENCY,
    parameter int RES_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    pipe_in_valid,
    output logic [DATA_W-1:0]       pipe_in_data,
    input  logic [DATA_W-1:0]       pipe_out_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [N_REQ*DATA_W-1:0] rsp_data,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic                    busy
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);

    logic [CNT_W-1:0]  credit [N_REQ];
    tag_t              rr_ptr;
    tag_t              pipe_in_tag;
    slot_t             shift [LATENCY];
    slot_t             tail;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant;
    logic              grant_any;
    tag_t              grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic [N_REQ-1:0]  rsp_pop;
    logic [N_REQ-1:0]  fifo_push;

    // Nothing is granted while reset is held, so no op slips in during reset.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = reset & req_valid[i] & (credit[i] != '0);
        end
    end

    // Two passes: indices at/above rr_ptr first, then wrap to the lowest eligible.
    always_comb begin
        // NOTE: every output gets a default before the loops so no latch is inferred.
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && eligible[i] && (tag_t'(i) >= rr_ptr)) begin
                grant_any = 1'b1;
                grant_idx = tag_t'(i);
                grant[i]  = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && eligible[i]) begin
                grant_any = 1'b1;
                grant_idx = tag_t'(i);
                grant[i]  = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign req_ready = grant;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign tail      = shift[LATENCY-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr        <= '0;
            pipe_in_valid <= 1'b0;
            pipe_in_data  <= '0;
            pipe_in_tag   <= '0;
            for (int i = 0; i < N_REQ; i++) credit[i] <= CNT_W'(RES_DEPTH);
            for (int k = 0; k < LATENCY; k++) shift[k] <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            pipe_in_valid <= grant_any;
            if (grant_any) begin
                pipe_in_data <= grant_data;
                pipe_in_tag  <= grant_idx;
                rr_ptr       <= (grant_idx == tag_t'(N_REQ - 1)) ? '0 : grant_idx + tag_t'(1);
            end
            shift[0] <= '{vld: pipe_in_valid, tag: pipe_in_tag};
            for (int k = 1; k < LATENCY; k++) shift[k] <= shift[k-1];
            for (int i = 0; i < N_REQ; i++) begin
                case ({grant[i], rsp_pop[i]})
                    2'b10:   credit[i] <= credit[i] - CNT_W'(1);
                    2'b01:   credit[i] <= credit[i] + CNT_W'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        assign fifo_push[i] = tail.vld && (tail.tag == tag_t'(i));

        sched_res_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (RES_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (fifo_push[i]),
            .push_data (pipe_out_data),
            .pop       (rsp_ready[i]),
            .not_empty (rsp_valid[i]),
            .head      (rsp_data[i*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        busy = pipe_in_valid | (|rsp_valid);
        for (int k = 0; k < LATENCY; k++) busy = busy | shift[k].vld;
    end

endmodule
